// File: rtl/hazard_pkg.sv
// Shared types for the hazard stall controller: in-flight write tracking entry and its empty value.
package hazard_pkg;

  localparam int REG_ADDR_W = 4;

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_r_en;
    logic [REG_ADDR_W-1:0] dest;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/hazard_track_stage.sv
// One slot of the in-flight write shadow pipeline: clears on rst, holds while frozen, else loads.
module hazard_track_stage
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SB_EMPTY;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/bubble/flush sequencing for the 5-stage core, covering hazards forwarding cannot resolve.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int PERF_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_wb_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_mem_r_en,
  input  logic                  branch_taken,
  input  logic                  forward_en,
  input  logic                  pipe_freeze,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic [PERF_CNT_W-1:0] stall_cycles
);

  import hazard_pkg::*;

  // Index 0 = EX, 1 = MEM, 2 = WB; WB is tracked but never compared (register file writes before read).
  sb_entry_t sb_d [3];
  sb_entry_t sb_q [3];
  logic      raw;

  function automatic logic hit(input sb_entry_t e,
                               input logic [REG_ADDR_W-1:0] s1,
                               input logic [REG_ADDR_W-1:0] s2,
                               input logic two);
    hit = e.valid & e.wb_en & ((e.dest == s1) | (two & (e.dest == s2)));
  endfunction

  always_comb begin
    raw = 1'b0;
    if (forward_en) begin
      raw = id_valid & hit(sb_q[0], id_src1, id_src2, id_two_src) & sb_q[0].mem_r_en;
    end else begin
      raw = id_valid & (hit(sb_q[0], id_src1, id_src2, id_two_src) |
                        hit(sb_q[1], id_src1, id_src2, id_two_src));
    end
  end

  assign flush  = branch_taken;
  assign stall  = raw & ~branch_taken;
  assign bubble = stall | branch_taken;

  always_comb begin
    sb_d[0] = SB_EMPTY;
    if (!bubble && id_valid) begin
      sb_d[0].valid    = 1'b1;
      sb_d[0].wb_en    = id_wb_en;
      sb_d[0].mem_r_en = id_mem_r_en;
      sb_d[0].dest     = id_dest;
    end
    sb_d[1] = sb_q[0];
    sb_d[2] = sb_q[1];
  end

  for (genvar i = 0; i < 3; i++) begin : g_track
    hazard_track_stage u_stage (
      .clk  (clk),
      .rst  (rst),
      .hold (pipe_freeze),
      .d    (sb_d[i]),
      .q    (sb_q[i])
    );
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt;

  // Counts only cycles that actually advance the pipeline; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !pipe_freeze && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
